// File: rtl/strobe_monitor_pkg.sv
// strobe_monitor_pkg: state encoding shared by the strobe monitor and anything decoding its state
package strobe_monitor_pkg;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_FIRST,
      ST_MEASURE,
      ST_LOCKED
   } sm_state_e;
endpackage

// File: rtl/strobe_period_counter.sv
// strobe_period_counter: elapsed-clock counter with clear, load-1 and saturation at MAX
module strobe_period_counter #(
   parameter int MAX = 80,
   parameter int W = $clog2(MAX + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         sat_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign sat_o = cnt_q == W'(MAX);
   assign cnt_o = cnt_q;
   always_comb cnt_d = clr_i ? '0 : load_i ? W'(1) : (inc_i && !sat_o) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/strobe_monitor.sv
// strobe_monitor: measures strobe periods, declares lock, flags out-of-tolerance and missing strobes
module strobe_monitor
   import strobe_monitor_pkg::*;
#(
   parameter int EXPECTED_CLKS = 40,
   parameter int TOLERANCE = 1,
   parameter int LOCK_COUNT = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   enable_i,
   input  logic                                   strobe_i,
   output logic [$clog2(2*EXPECTED_CLKS+1)-1:0]   period_o,
   output logic                                   period_valid_o,
   output logic                                   locked_o,
   output logic                                   error_o,
   output logic                                   missing_o
);
   localparam int W = $clog2(2 * EXPECTED_CLKS + 1);
   localparam int TIMEOUT = 2 * EXPECTED_CLKS;
   localparam int LOW = EXPECTED_CLKS - TOLERANCE;
   localparam int HIGH = EXPECTED_CLKS + TOLERANCE;
   localparam int GW = $clog2(LOCK_COUNT + 1);
   sm_state_e state_q, state_d;
   logic [W-1:0] period_q, period_d, cnt;
   logic [GW-1:0] good_q, good_d, good_inc;
   logic pv_q, pv_d, err_q, err_d, miss_q, miss_d;
   logic sat, clr, load, inc, in_tol;
   strobe_period_counter #(.MAX(TIMEOUT), .W(W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr),
      .load_i(load),
      .inc_i (inc),
      .cnt_o (cnt),
      .sat_o (sat)
   );
   assign in_tol = cnt >= W'(LOW) && cnt <= W'(HIGH);
   assign good_inc = good_q == GW'(LOCK_COUNT) ? good_q : good_q + 1'b1;
   // a strobe coinciding with the timeout is measured, never reported missing
   always_comb begin
      state_d = state_q;
      period_d = period_q;
      good_d = good_q;
      pv_d = 1'b0;
      err_d = 1'b0;
      miss_d = 1'b0;
      clr = 1'b0;
      load = 1'b0;
      inc = state_q == ST_MEASURE || state_q == ST_LOCKED;
      if (!enable_i) begin
         state_d = ST_IDLE;
         good_d = '0;
         clr = 1'b1;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_WAIT_FIRST;
      end else if (state_q == ST_WAIT_FIRST) begin
         load = strobe_i;
         state_d = strobe_i ? ST_MEASURE : ST_WAIT_FIRST;
      end else if (strobe_i) begin
         period_d = cnt;
         pv_d = 1'b1;
         load = 1'b1;
         err_d = !in_tol;
         good_d = in_tol ? good_inc : '0;
         state_d = (in_tol && good_inc == GW'(LOCK_COUNT)) ? ST_LOCKED : ST_MEASURE;
      end else if (sat) begin
         miss_d = 1'b1;
         good_d = '0;
         clr = 1'b1;
         state_d = ST_WAIT_FIRST;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         period_q <= '0;
         good_q <= '0;
         pv_q <= 1'b0;
         err_q <= 1'b0;
         miss_q <= 1'b0;
      end else begin
         state_q <= state_d;
         period_q <= period_d;
         good_q <= good_d;
         pv_q <= pv_d;
         err_q <= err_d;
         miss_q <= miss_d;
      end
   end
   assign period_o = period_q;
   assign period_valid_o = pv_q;
   assign locked_o = state_q == ST_LOCKED;
   assign error_o = err_q;
   assign missing_o = miss_q;
endmodule

// File: tb/tb_strobe_monitor.sv
// tb_strobe_monitor: directed checks of the default-parameter monitor and a minimal 2/0/1 instance
module tb_strobe_monitor;
   import strobe_monitor_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_a = 1'b0, st_a = 1'b0, en_b = 1'b0, st_b = 1'b0;
   logic [6:0] period_a;
   logic [2:0] period_b;
   logic pv_a, lk_a, err_a, miss_a, pv_b, lk_b, err_b, miss_b;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   strobe_monitor dut_a (
      .clk_i(clk), .rst_i(rst), .enable_i(en_a), .strobe_i(st_a),
      .period_o(period_a), .period_valid_o(pv_a), .locked_o(lk_a),
      .error_o(err_a), .missing_o(miss_a)
   );
   strobe_monitor #(.EXPECTED_CLKS(2), .TOLERANCE(0), .LOCK_COUNT(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .enable_i(en_b), .strobe_i(st_b),
      .period_o(period_b), .period_valid_o(pv_b), .locked_o(lk_b),
      .error_o(err_b), .missing_o(miss_b)
   );
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) tick();
   endtask
   task automatic pulse(input bit b);
      if (b) st_b = 1'b1;
      else st_a = 1'b1;
      tick();
      st_a = 1'b0;
      st_b = 1'b0;
   endtask
   task automatic period(input bit b, input int p);
      idle(p - 1);
      pulse(b);
   endtask
   initial begin
      idle(2);
      chk("rst_period", int'(period_a), 0);
      chk("rst_pv", int'(pv_a), 0);
      chk("rst_lock", int'(lk_a), 0);
      chk("rst_err", int'(err_a), 0);
      chk("rst_miss", int'(miss_a), 0);
      chk("rst_state", int'(dut_a.state_q), int'(ST_IDLE));
      rst = 1'b0;
      en_a = 1'b1;
      tick();
      chk("en_state", int'(dut_a.state_q), int'(ST_WAIT_FIRST));
      pulse(0);
      chk("arm_pv", int'(pv_a), 0);
      chk("arm_state", int'(dut_a.state_q), int'(ST_MEASURE));
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("pv_drop", int'(pv_a), 0);
         idle(38);
         pulse(0);
         chk("nom_pv", int'(pv_a), 1);
         chk("nom_period", int'(period_a), 40);
         chk("nom_err", int'(err_a), 0);
         chk("nom_lock", int'(lk_a), k >= 4 ? 1 : 0);
      end
      period(0, 41);
      chk("p41_period", int'(period_a), 41);
      chk("p41_lock", int'(lk_a), 1);
      period(0, 39);
      chk("p39_lock", int'(lk_a), 1);
      chk("p39_err", int'(err_a), 0);
      period(0, 42);
      chk("p42_period", int'(period_a), 42);
      chk("p42_err", int'(err_a), 1);
      chk("p42_lock", int'(lk_a), 0);
      tick();
      chk("p42_err_drop", int'(err_a), 0);
      idle(38);
      pulse(0);
      chk("relock1", int'(lk_a), 0);
      for (int k = 2; k <= 4; k++) begin
         period(0, 40);
         chk("relock", int'(lk_a), k == 4 ? 1 : 0);
      end
      idle(79);
      chk("miss_early", int'(miss_a), 0);
      chk("miss_early_lock", int'(lk_a), 1);
      tick();
      chk("miss_pulse", int'(miss_a), 1);
      chk("miss_lock", int'(lk_a), 0);
      chk("miss_state", int'(dut_a.state_q), int'(ST_WAIT_FIRST));
      tick();
      chk("miss_drop", int'(miss_a), 0);
      pulse(0);
      chk("rearm_pv", int'(pv_a), 0);
      chk("rearm_state", int'(dut_a.state_q), int'(ST_MEASURE));
      period(0, 80);
      chk("to_period", int'(period_a), 80);
      chk("to_err", int'(err_a), 1);
      chk("to_miss", int'(miss_a), 0);
      chk("to_pv", int'(pv_a), 1);
      tick();
      chk("to_miss_after", int'(miss_a), 0);
      pulse(0);
      chk("p2_period", int'(period_a), 2);
      pulse(0);
      chk("b2b_period", int'(period_a), 1);
      chk("b2b_err", int'(err_a), 1);
      for (int k = 1; k <= 4; k++) period(0, 40);
      chk("prerst_lock", int'(lk_a), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_period", int'(period_a), 0);
      chk("mrst_lock", int'(lk_a), 0);
      chk("mrst_pv", int'(pv_a), 0);
      chk("mrst_state", int'(dut_a.state_q), int'(ST_IDLE));
      tick();
      chk("mrst_resume", int'(dut_a.state_q), int'(ST_WAIT_FIRST));
      pulse(0);
      period(0, 40);
      chk("dis_pre_period", int'(period_a), 40);
      idle(5);
      en_a = 1'b0;
      pulse(0);
      chk("dis_state", int'(dut_a.state_q), int'(ST_IDLE));
      chk("dis_pv", int'(pv_a), 0);
      chk("dis_err", int'(err_a), 0);
      chk("dis_period_hold", int'(period_a), 40);
      pulse(0);
      chk("dis_ignored", int'(pv_a), 0);
      en_a = 1'b1;
      tick();
      chk("reen_state", int'(dut_a.state_q), int'(ST_WAIT_FIRST));
      pulse(0);
      chk("reen_arm_pv", int'(pv_a), 0);
      en_b = 1'b1;
      tick();
      chk("b_en_state", int'(dut_b.state_q), int'(ST_WAIT_FIRST));
      pulse(1);
      chk("b_arm_pv", int'(pv_b), 0);
      period(1, 2);
      chk("b_period", int'(period_b), 2);
      chk("b_pv", int'(pv_b), 1);
      chk("b_lock", int'(lk_b), 1);
      chk("b_err", int'(err_b), 0);
      period(1, 3);
      chk("b_p3_err", int'(err_b), 1);
      chk("b_p3_lock", int'(lk_b), 0);
      period(1, 2);
      chk("b_relock", int'(lk_b), 1);
      idle(3);
      chk("b_miss_early", int'(miss_b), 0);
      tick();
      chk("b_miss", int'(miss_b), 1);
      chk("b_miss_lock", int'(lk_b), 0);
      pulse(1);
      period(1, 4);
      chk("b_to_period", int'(period_b), 4);
      chk("b_to_err", int'(err_b), 1);
      chk("b_to_miss", int'(miss_b), 0);
      pulse(1);
      chk("b_b2b_period", int'(period_b), 1);
      chk("b_b2b_err", int'(err_b), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/strobe_monitor.md
# strobe_monitor

Receive-side checker for the periodic strobes that drive sample generation in the wave generator. Measures the number of clocks between consecutive strobes and reports each period. Declares lock once the period has been in tolerance for several strobes in a row. Flags out-of-tolerance periods and missing strobes. Sits at the consumer end of the strobe path, in front of any block that needs a trusted sample rate.

## Interface
- `EXPECTED_CLKS`, default 40: nominal clocks between strobes; must be ≥ 2.
- `TOLERANCE`, default 1: allowed absolute deviation in clocks; must be < `EXPECTED_CLKS`.
- `LOCK_COUNT`, default 4: consecutive in-tolerance periods required for lock; must be ≥ 1.
- `clk_i` input 1: system clock. One clock domain.
- `rst_i` input 1: reset, synchronous, active-high.
- `enable_i` input 1: monitor enable. Low forces the IDLE state.
- `strobe_i` input 1: incoming strobe, one-cycle pulse, synchronous to `clk_i`.
- `period_o` output W: last measured period, where W = $clog2(2*EXPECTED_CLKS+1).
- `period_valid_o` output 1: one-cycle pulse; `period_o` updated this cycle.
- `locked_o` output 1: level; high while in the LOCKED state.
- `error_o` output 1: one-cycle pulse; the last period was outside tolerance.
- `missing_o` output 1: one-cycle pulse; no strobe arrived within the timeout.

## Operation
- TIMEOUT = 2*EXPECTED_CLKS. A period is in tolerance when |period − EXPECTED_CLKS| ≤ TOLERANCE. Compare without unsigned underflow, for example low ≤ period ≤ high.
- The elapsed counter `cnt` is W bits wide.
  - It loads 1 in the cycle after a strobe is accepted.
  - It then increments by 1 each cycle.
  - It saturates at TIMEOUT.
  - So, for a strobe at cycle t0, `cnt` equals N at cycle t0+N.
- The run counter `good` is $clog2(LOCK_COUNT+1) bits wide.
- States and transitions (enable_i low overrides all of them):
  - Any state, `enable_i` = 0: go to IDLE. Clear `cnt` and `good`. All pulses stay 0; `period_o` holds its value.
  - IDLE, `enable_i` = 1: go to WAIT_FIRST.
  - WAIT_FIRST, strobe: arm only. Load `cnt` = 1, go to MEASURE. No `period_valid_o` is produced.
  - MEASURE or LOCKED, strobe: latch `period_o` = `cnt`, pulse `period_valid_o`, reload `cnt` = 1.
    - In tolerance: `good` += 1, saturating at LOCK_COUNT. When `good` reaches LOCK_COUNT, go to LOCKED.
    - Out of tolerance: pulse `error_o`, clear `good`, go to MEASURE (this drops lock).
  - MEASURE or LOCKED, no strobe, `cnt` == TIMEOUT: pulse `missing_o`, clear `good`, go to WAIT_FIRST.
- Boundary cases:
  - Strobe in the same cycle as `cnt` == TIMEOUT: the strobe wins. Period = TIMEOUT, which is out of tolerance, so `error_o` pulses and `missing_o` does not.
  - Back-to-back strobes: period = 1, which gives `error_o`.
  - Strobe in the same cycle that `enable_i` falls: ignored.
  - `rst_i` mid-operation: on the next edge, state is IDLE and every register returns to its reset value.

## Timing
- `strobe_i` is sampled at edge t. `period_o`, `period_valid_o`, `error_o` and the transition of `locked_o` are visible after edge t+1. Latency is 1 cycle, and all outputs are registered.
- `missing_o` is asserted the cycle after `cnt` == TIMEOUT is observed, which is TIMEOUT+1 cycles after the last strobe.
- Reset values:
  - `period_o` = 0
  - `period_valid_o` = 0
  - `locked_o` = 0
  - `error_o` = 0
  - `missing_o` = 0
  - state = IDLE
- The block is ready the cycle after reset. It leaves IDLE on the first edge with `enable_i` = 1.

## Structure
- State encoding, TIMEOUT and the tolerance bounds are localparams derived from the parameters. The state encoding goes into the shared wave-generator constants include so the bench can decode state.
- One sub-module: `strobe_period_counter`. It is a saturating counter with synchronous load-1, clear and saturate flag, parameterised by maximum value.
- The FSM, tolerance compare and pulse registers stay in `strobe_monitor`.

## Test plan
- Enable with strobes every 40 clocks (defaults): `period_valid_o` with `period_o` = 40 on every strobe after the first. `locked_o` rises 1 cycle after the 5th strobe (the 4th measured period) and no `error_o`.
- While locked, inject a single period of 42, then return to 40: `error_o` one pulse, `locked_o` falls with it, and relock after 4 further good periods. Period 41 keeps lock.
- Stop strobes after lock: `missing_o` pulses once, 81 cycles after the last strobe; `locked_o` = 0. The next strobe only re-arms, with no `period_valid_o`.
- Strobe exactly at `cnt` = 80: `error_o` pulse with `period_o` = 80, no `missing_o`. Strobes on consecutive cycles: `period_o` = 1 and `error_o`.
- Assert `rst_i` for 1 cycle mid-lock: all outputs 0 on the next cycle, state IDLE. Deassert `enable_i` mid-measure: IDLE, with strobes ignored.
- Parameters `EXPECTED_CLKS` = 2, `TOLERANCE` = 0, `LOCK_COUNT` = 1: lock 1 cycle after the 2nd strobe spaced 2 apart. Checks width edge cases.
